// File: rtl/demux_grant_scheduler.sv
// demux_grant_scheduler: round-robin owner of a 2-to-4 demux with break-before-make (GRANT -> GAP -> IDLE)
// Ports: clk, rst_n (async active-low), req[3:0] level requests, done owner-finished pulse,
//        sel[1:0] demux select (sel[1]->x1, sel[0]->x2), grant[3:0] one-hot, valid, busy, timeout.
// Optional hold timeout enabled by defining DEMUX_SCHED_HOLD_TIMEOUT_EN (uses MAX_HOLD, CNT_W).
module demux_grant_scheduler #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] sel,
  output logic [3:0] grant,
  output logic       valid,
  output logic       busy,
  output logic       timeout
);
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  state_t state, state_n;
  logic [1:0] sel_n, ptr, ptr_n, pick;
  logic rel, limit;
  always_comb begin
    pick = ptr;
    for (int k = 3; k >= 0; k--)
      if (req[ptr + 2'(k)]) pick = ptr + 2'(k);
  end
  assign rel = done | ~req[sel];
  always_comb begin
    state_n = state;
    sel_n = sel;
    ptr_n = ptr;
    case (state)
      IDLE: if (|req) begin
        state_n = GRANT;
        sel_n = pick;
      end
      GRANT: if (rel | limit) begin
        state_n = GAP;
        ptr_n = sel + 2'd1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sel <= '0;
      ptr <= '0;
      grant <= '0;
      valid <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      sel <= sel_n;
      ptr <= ptr_n;
      grant <= state_n == GRANT ? 4'd1 << sel_n : 4'd0;
      valid <= state_n == GRANT;
      busy <= state_n != IDLE;
    end
`ifdef DEMUX_SCHED_HOLD_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt, hold_n;
  assign limit = hold_cnt == CNT_W'(MAX_HOLD);
  always_comb hold_n = state == IDLE ? CNT_W'(1) :
                       (state == GRANT && hold_cnt != '1) ? hold_cnt + CNT_W'(1) : hold_cnt;
  // a normal release on the limit cycle takes priority and suppresses timeout
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hold_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      hold_cnt <= hold_n;
      timeout <= state == GRANT & limit & ~rel;
    end
`else
  logic unused_cfg;
  assign unused_cfg = ^{MAX_HOLD, CNT_W};
  assign limit = 1'b0;
  assign timeout = 1'b0;
`endif
endmodule
